// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard unit.
//   md_state_e : mul/div occupancy FSM states (RUN, BUSY, DONE)
//   FWD_*      : EX operand forwarding select encodings
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_unit_md_stall_fsm.sv
// Multi-cycle multiply/divide occupancy sequencer.
//   clk, rst    : clock, asynchronous active-high reset
//   md_start    : EX holds a mul/div instruction
//   md_is_div   : 1 = divide latency, 0 = multiply latency
//   md_busy     : combinational; EX is held by a mul/div this cycle
//   md_done     : registered; high in the cycle the result advances
//   state       : current FSM state (debug / consumed by hazard logic)
// A start in RUN is the first stall cycle; BUSY then counts the remaining
// LAT-1 stall cycles down to zero, so total stall = LAT exactly.
module md_stall_fsm
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      md_start,
  input  logic      md_is_div,
  output logic      md_busy,
  output logic      md_done,
  output md_state_e state
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;

  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 2);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 2);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          md_done_q, md_done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_busy = 1'b0;
    case (state_q)
      RUN: begin
        if (md_start) begin
          md_busy = 1'b1;
          cnt_d   = md_is_div ? DIV_LOAD : MUL_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        md_busy = 1'b1;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      DONE: begin
        // md_start still high belongs to the finishing instruction; ignore it.
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    md_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      md_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_done_q <= md_done_d;
    end
  end

  assign md_done = md_done_q;
  assign state   = state_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: ld/clr pairs for IF/ID, ID/EX, EX/MEM, MEM/WB,
// PC load enable, EX forwarding selects, mul/div stall sequencing and a
// saturating stall-cycle counter.
//   id_*  : ID instruction sources and use flags (load-use detection)
//   ex_*  : EX instruction sources/dest, load flag, taken branch, mul/div start
//   mem_*/wb_* : downstream destinations and write enables (forwarding)
//   pc_ld, *_ld, *_clr : pipeline register controls (clr beats ld)
//   fwd_a, fwd_b : 00 regfile, 10 MEM, 01 WB
//   md_busy, md_done : mul/div stall / completion
//   stall_cycles : number of cycles with pc_ld low, saturating
// Priority per cycle: mul/div stall > taken branch > load-use.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic              md_start,
  input  logic              md_is_div,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  output logic              pc_ld,
  output logic              ifid_ld,
  output logic              ifid_clr,
  output logic              idex_ld,
  output logic              idex_clr,
  output logic              exmem_ld,
  output logic              exmem_clr,
  output logic              memwb_ld,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              md_busy,
  output logic              md_done,
  output logic [CNT_W-1:0]  stall_cycles
);

  md_state_e md_state;
  logic      load_use;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  md_stall_fsm #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_fsm (
    .clk       (clk),
    .rst       (rst),
    .md_start  (md_start),
    .md_is_div (md_is_div),
    .md_busy   (md_busy),
    .md_done   (md_done),
    .state     (md_state)
  );

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] m_rd,
    input logic              m_we,
    input logic [REG_AW-1:0] w_rd,
    input logic              w_we
  );
    if (m_we && (m_rd != '0) && (m_rd == rs))      return FWD_MEM;
    else if (w_we && (w_rd != '0) && (w_rd == rs)) return FWD_WB;
    else                                           return FWD_REG;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    fwd_b = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  end

  // Load-use only applies in RUN; md_busy already covers RUN & md_start.
  always_comb begin
    load_use = (md_state == RUN) && !md_busy && ex_mem_read && (ex_rd != '0) &&
               ((id_use_rs1 && (ex_rd == id_rs1)) ||
                (id_use_rs2 && (ex_rd == id_rs2)));
  end

  always_comb begin
    pc_ld     = 1'b1;
    ifid_ld   = 1'b1;
    ifid_clr  = 1'b0;
    idex_ld   = 1'b1;
    idex_clr  = 1'b0;
    exmem_ld  = 1'b1;
    exmem_clr = 1'b0;
    memwb_ld  = 1'b1;
    if (md_busy) begin
      // Freeze front end, hold EX, inject a bubble into EX/MEM.
      pc_ld     = 1'b0;
      ifid_ld   = 1'b0;
      idex_ld   = 1'b0;
      exmem_clr = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_clr = 1'b1;
      idex_clr = 1'b1;
    end else if (load_use) begin
      pc_ld    = 1'b0;
      ifid_ld  = 1'b0;
      idex_clr = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_ld && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit. Driver issues one input vector per cycle and
// pushes the reference model's expected outputs; the monitor pops and
// compares on every sampled cycle.
// Handshake: every non-reset cycle is one transaction; the DUT presents a
// response (its combinational controls plus registered status) every cycle.
module tb_hazard_unit;

  localparam int REG_AW  = 5;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 32;
  localparam int CNT_W   = 32;
  localparam int VW      = 46;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic              id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
  logic              md_start, md_is_div, mem_reg_write, wb_reg_write;
  logic              pc_ld, ifid_ld, ifid_clr, idex_ld, idex_clr;
  logic              exmem_ld, exmem_clr, memwb_ld, md_busy, md_done;
  logic [1:0]        fwd_a, fwd_b;
  logic [CNT_W-1:0]  stall_cycles;

  // clock/reset block
  always #5 clk = ~clk;

  hazard_unit #(
    .REG_AW (REG_AW), .MUL_LAT (MUL_LAT), .DIV_LAT (DIV_LAT), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst (rst),
    .id_rs1 (id_rs1), .id_rs2 (id_rs2),
    .id_use_rs1 (id_use_rs1), .id_use_rs2 (id_use_rs2),
    .ex_rs1 (ex_rs1), .ex_rs2 (ex_rs2), .ex_rd (ex_rd),
    .ex_mem_read (ex_mem_read), .ex_branch_taken (ex_branch_taken),
    .md_start (md_start), .md_is_div (md_is_div),
    .mem_rd (mem_rd), .wb_rd (wb_rd),
    .mem_reg_write (mem_reg_write), .wb_reg_write (wb_reg_write),
    .pc_ld (pc_ld), .ifid_ld (ifid_ld), .ifid_clr (ifid_clr),
    .idex_ld (idex_ld), .idex_clr (idex_clr),
    .exmem_ld (exmem_ld), .exmem_clr (exmem_clr), .memwb_ld (memwb_ld),
    .fwd_a (fwd_a), .fwd_b (fwd_b),
    .md_busy (md_busy), .md_done (md_done), .stall_cycles (stall_cycles)
  );

  function automatic logic [VW-1:0] pack(
    input logic pc, input logic ifl, input logic ifc, input logic idl,
    input logic idc, input logic exl, input logic exc, input logic mwl,
    input logic [1:0] fa, input logic [1:0] fb, input logic busy,
    input logic done, input logic [31:0] sc
  );
    return {pc, ifl, ifc, idl, idc, exl, exc, mwl, fa, fb, busy, done, sc};
  endfunction

  logic [VW-1:0] act_vec;
  assign act_vec = pack(pc_ld, ifid_ld, ifid_clr, idex_ld, idex_clr, exmem_ld,
                        exmem_clr, memwb_ld, fwd_a, fwd_b, md_busy, md_done,
                        stall_cycles);

  // scoreboard
  logic [VW-1:0] exp_q[$];
  string         tag_q[$];
  int            checks = 0;
  int            errors = 0;

  // reference model: stall cycles still owed by the current mul/div,
  // a completion flag, and a plain integer stall count
  int     m_rem  = 0;
  bit     m_done = 0;
  longint m_scnt = 0;

  function automatic logic [1:0] ref_fwd(input int rs);
    if (mem_reg_write && mem_rd != 0 && int'(mem_rd) == rs) return 2'b10;
    if (wb_reg_write && wb_rd != 0 && int'(wb_rd) == rs)    return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_rem  = 0;
    m_done = 0;
    m_scnt = 0;
  endtask

  // Issue the current inputs for one cycle; returns after the next negedge.
  task automatic step(input string tag);
    bit md_stall, br, lu, front_stall;
    md_stall = (m_rem > 0) || (!m_done && md_start);
    br = !md_stall && ex_branch_taken;
    lu = !md_stall && !m_done && !br && ex_mem_read && ex_rd != 0 &&
         ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    front_stall = md_stall || lu;
    exp_q.push_back(pack(!front_stall, !front_stall, br, !md_stall, br || lu,
                         1'b1, md_stall, 1'b1, ref_fwd(int'(ex_rs1)),
                         ref_fwd(int'(ex_rs2)), md_stall, m_done,
                         m_scnt[31:0]));
    tag_q.push_back(tag);
    if (front_stall && m_scnt < 64'hFFFF_FFFF) m_scnt++;
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) m_done = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (md_start) begin
      m_rem = (md_is_div ? DIV_LAT : MUL_LAT) - 1;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken} = '0;
    {md_start, md_is_div, mem_reg_write, wb_reg_write}     = '0;
  endtask

  task automatic random_inputs();
    id_rs1 = REG_AW'($urandom_range(0, 7));
    id_rs2 = REG_AW'($urandom_range(0, 7));
    ex_rs1 = REG_AW'($urandom_range(0, 7));
    ex_rs2 = REG_AW'($urandom_range(0, 7));
    ex_rd  = REG_AW'($urandom_range(0, 7));
    mem_rd = REG_AW'($urandom_range(0, 7));
    wb_rd  = REG_AW'($urandom_range(0, 7));
    id_use_rs1      = 1'($urandom_range(0, 1));
    id_use_rs2      = 1'($urandom_range(0, 1));
    ex_mem_read     = 1'($urandom_range(0, 1));
    ex_branch_taken = ($urandom_range(0, 5) == 0);
    md_start        = ($urandom_range(0, 9) == 0);
    md_is_div       = ($urandom_range(0, 3) == 0);
    mem_reg_write   = 1'($urandom_range(0, 1));
    wb_reg_write    = 1'($urandom_range(0, 1));
  endtask

  // Reset asserted for one full cycle starting at a negedge.
  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // monitor
  initial begin
    logic [VW-1:0] exp_v;
    string         t;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        t     = tag_q.pop_front();
        checks++;
        if (act_vec !== exp_v) begin
          errors++;
          $display("FAIL %s: got %h expected %h (t=%0t)", t, act_vec, exp_v, $time);
        end
      end
    end
  end

  // driver
  initial begin
    rst = 1'b1;
    random_inputs();
    repeat (3) @(negedge clk);
    random_inputs();
    md_start = 1'b0;
    model_reset();
    rst = 1'b0;
    step("reset_exit_random");
    clear_inputs();
    step("idle_all_ld");
    step("idle_all_ld2");

    // load-use on rs1
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    step("load_use");
    clear_inputs();
    step("after_load_use");

    // multiply held four cycles, then dropped
    md_start = 1'b1; md_is_div = 1'b0;
    repeat (4) step("mul_seq");
    md_start = 1'b0;
    step("mul_after");

    // divide aborted by reset after 10 stall cycles
    md_start = 1'b1; md_is_div = 1'b1;
    repeat (10) step("div_run");
    md_start = 1'b0; md_is_div = 1'b0;
    pulse_reset();
    step("div_reset_abort");

    // branch beats load-use
    ex_branch_taken = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_use_rs2 = 1'b1;
    step("branch_vs_load_use");
    clear_inputs();

    // forwarding priority
    mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    ex_rs1 = 5'd7; ex_rs2 = 5'd0;
    step("fwd_mem_wins");
    mem_reg_write = 1'b0;
    step("fwd_wb");
    ex_rs1 = 5'd0; mem_reg_write = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
    step("fwd_x0");
    clear_inputs();

    // full divide to completion
    md_start = 1'b1; md_is_div = 1'b1;
    repeat (DIV_LAT + 1) step("div_full");
    clear_inputs();
    step("div_after");

    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      random_inputs();
      if ($urandom_range(0, 299) == 0) begin
        md_start = 1'b0;
        pulse_reset();
      end
      step("random");
    end

    #5;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
